imem_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the 8-bit processor. It owns the program counter and drives the 8-bit address of the combinational-read instruction memory (`imem`, 16-bit words). It buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake. It also handles branch redirects and stops fetching on a halt word.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 47 ++++
 rtl/imem_fetch_ctrl.sv | 103 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 16;
   localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 16'hFFFF;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {instr, pc} pairs; flush empties it in one cycle.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  entry_t     push_data,
   input  logic       pop,
   input  logic       flush,
   output entry_t     head,
   output logic [1:0] count
);

   entry_t slot [2];
   logic   rd_ptr;
   logic   wr_ptr;

   // When full with a simultaneous pop, wr_ptr equals rd_ptr, so the push lands in the slot being freed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot[0] <= '0;
         slot[1] <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         count   <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

   assign head = slot[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, fills a 2-entry queue toward decode,
// honours branch redirects and stops after fetching the halt word.
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  BOOT_ADDR = 8'h00,
   parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rd,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               busy,
   output logic               halted,
   output logic               pc_wrap
);

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        count;
   entry_t            head;
   entry_t            fetch_entry;
   logic              pop;
   logic              fetch;
   logic              flush;

   // Redirect outranks everything outside IDLE and suppresses that cycle's fetch.
   assign flush       = redirect && (state != IDLE);
   assign pop         = instr_valid && instr_ready;
   assign fetch       = (state == RUN) && !redirect && ((count != 2'd2) || pop);
   assign fetch_entry = '{instr: imem_rd, pc: pc};

   fetch_queue u_queue (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fetch),
      .push_data (fetch_entry),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count)
   );

   assign instr_valid = (count != 2'd0);
   assign instr       = head.instr;
   assign instr_pc    = head.pc;
   assign imem_addr   = pc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         pc      <= BOOT_ADDR;
         busy    <= 1'b0;
         halted  <= 1'b0;
         pc_wrap <= 1'b0;
      end else begin
         pc_wrap <= fetch && (pc == '1);
         if (flush) begin
            state  <= RUN;
            pc     <= redirect_pc;
            busy   <= 1'b1;
            halted <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
               RUN: begin
                  if (fetch) begin
                     pc <= pc + 1'b1;
                     if (imem_rd == HALT_WORD) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  // No fetches here, so the queue empties exactly when its last entry pops.
                  if ((count == 2'd1) && pop) begin
                     state  <= HALT;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end
               end
               HALT: ;
               default: begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  halted <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a combinational instruction memory model.
module tb_imem_fetch_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rd;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        busy;
   logic        halted;
   logic        pc_wrap;

   logic [15:0] mem [256];
   int passed;
   int total;

   imem_fetch_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .imem_addr   (imem_addr),
      .imem_rd     (imem_rd),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .busy        (busy),
      .halted      (halted),
      .pc_wrap     (pc_wrap)
   );

   assign imem_rd = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      start       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      instr_ready = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      start = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
      reset_n = 1'b0;
      #3;
      total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else passed++;
      total++; if (instr !== 16'h0000) $display("FAIL rst_instr: got %h want 0000", instr); else passed++;
      total++; if (instr_pc !== 8'h00) $display("FAIL rst_instr_pc: got %h want 00", instr_pc); else passed++;
      total++; if (imem_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", imem_addr); else passed++;
      total++; if (busy !== 1'b0 || halted !== 1'b0 || pc_wrap !== 1'b0)
         $display("FAIL rst_flags: got busy=%b halted=%b wrap=%b want 0 0 0", busy, halted, pc_wrap); else passed++;
      @(posedge clk); #1;
      reset_n = 1'b1;
      redirect = 1'b1; redirect_pc = 8'h40;
      for (int i = 0; i < 3; i++) tick();
      total++; if (imem_addr !== 8'h00 || busy !== 1'b0 || instr_valid !== 1'b0)
         $display("FAIL idle_redirect_ignored: got addr=%h busy=%b valid=%b want 00 0 0", imem_addr, busy, instr_valid); else passed++;
      redirect = 1'b0;
   endtask

   task automatic test_start;
      logic [15:0] exp_w [4];
      exp_w[0] = 16'h4C05; exp_w[1] = 16'h2000; exp_w[2] = 16'hFC00; exp_w[3] = 16'hFE01;
      do_reset();
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++; if (imem_addr !== 8'h00 || busy !== 1'b1 || instr_valid !== 1'b0)
         $display("FAIL start_n1: got addr=%h busy=%b valid=%b want 00 1 0", imem_addr, busy, instr_valid); else passed++;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr !== exp_w[k] || halted !== 1'b0)
            $display("FAIL start_seq%0d: got valid=%b pc=%h instr=%h halted=%b want 1 %h %h 0",
                     k, instr_valid, instr_pc, instr, halted, 8'(k), exp_w[k]); else passed++;
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] exp_w [3];
      exp_w[0] = 16'h2000; exp_w[1] = 16'hFC00; exp_w[2] = 16'hFE01;
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      total++; if (imem_addr !== 8'h01 || instr_valid !== 1'b1 || instr_pc !== 8'h00)
         $display("FAIL bp_first: got addr=%h valid=%b pc=%h want 01 1 00", imem_addr, instr_valid, instr_pc); else passed++;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (imem_addr !== 8'h02 || instr_pc !== 8'h00 || instr !== 16'h4C05 || instr_valid !== 1'b1)
            $display("FAIL bp_hold%0d: got addr=%h pc=%h instr=%h valid=%b want 02 00 4c05 1",
                     i, imem_addr, instr_pc, instr, instr_valid); else passed++;
      end
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (instr_valid !== 1'b1 || instr_pc !== 8'(k + 1) || instr !== exp_w[k])
            $display("FAIL bp_release%0d: got valid=%b pc=%h instr=%h want 1 %h %h",
                     k, instr_valid, instr_pc, instr, 8'(k + 1), exp_w[k]); else passed++;
      end
   endtask

   task automatic test_redirect_pop;
      do_reset();
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h02)
         $display("FAIL redir_pre: got valid=%b pc=%h want 1 02", instr_valid, instr_pc); else passed++;
      redirect = 1'b1; redirect_pc = 8'h06;
      tick();
      redirect = 1'b0;
      total++; if (instr_valid !== 1'b0 || imem_addr !== 8'h06)
         $display("FAIL redir_r1: got valid=%b addr=%h want 0 06", instr_valid, imem_addr); else passed++;
      tick();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h06 || instr !== 16'h1006)
         $display("FAIL redir_r2: got valid=%b pc=%h instr=%h want 1 06 1006", instr_valid, instr_pc, instr); else passed++;
      tick();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h07 || instr !== 16'h1007)
         $display("FAIL redir_r3: got valid=%b pc=%h instr=%h want 1 07 1007", instr_valid, instr_pc, instr); else passed++;
   endtask

   task automatic test_halt;
      do_reset();
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      tick();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h04 || instr !== 16'hFFFF || busy !== 1'b1 || halted !== 1'b0)
         $display("FAIL halt_word: got valid=%b pc=%h instr=%h busy=%b halted=%b want 1 04 ffff 1 0",
                  instr_valid, instr_pc, instr, busy, halted); else passed++;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (instr_valid !== 1'b0 || halted !== 1'b1 || busy !== 1'b0 || imem_addr !== 8'h05)
            $display("FAIL halt_hold%0d: got valid=%b halted=%b busy=%b addr=%h want 0 1 0 05",
                     i, instr_valid, halted, busy, imem_addr); else passed++;
      end
      redirect = 1'b1; redirect_pc = 8'h00;
      tick();
      redirect = 1'b0;
      total++; if (busy !== 1'b1 || halted !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 8'h00)
         $display("FAIL halt_resume: got busy=%b halted=%b valid=%b addr=%h want 1 0 0 00",
                  busy, halted, instr_valid, imem_addr); else passed++;
      tick();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== 16'h4C05)
         $display("FAIL halt_refetch: got valid=%b pc=%h instr=%h want 1 00 4c05", instr_valid, instr_pc, instr); else passed++;
   endtask

   task automatic test_wrap;
      logic [7:0] exp_pc [4];
      int wraps;
      exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
      wraps = 0;
      do_reset();
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      redirect = 1'b1; redirect_pc = 8'hFE;
      tick();
      redirect = 1'b0;
      if (pc_wrap === 1'b1) wraps++;
      total++; if (instr_valid !== 1'b0 || imem_addr !== 8'hFE)
         $display("FAIL wrap_redir: got valid=%b addr=%h want 0 fe", instr_valid, imem_addr); else passed++;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (pc_wrap === 1'b1) wraps++;
         total++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k])
            $display("FAIL wrap_seq%0d: got valid=%b pc=%h want 1 %h", k, instr_valid, instr_pc, exp_pc[k]); else passed++;
         if (k == 1) begin
            total++; if (pc_wrap !== 1'b1) $display("FAIL wrap_pulse: got %b want 1", pc_wrap); else passed++;
         end
      end
      tick(); if (pc_wrap === 1'b1) wraps++;
      tick(); if (pc_wrap === 1'b1) wraps++;
      total++; if (wraps != 1) $display("FAIL wrap_count: got %0d pulses want 1", wraps); else passed++;
   endtask

   task automatic test_async_reset;
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      total++; if (instr_valid !== 1'b1 || imem_addr !== 8'h02)
         $display("FAIL areset_pre: got valid=%b addr=%h want 1 02", instr_valid, imem_addr); else passed++;
      #2;
      reset_n = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h33;
      #1;
      total++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 8'h00 || imem_addr !== 8'h00)
         $display("FAIL areset_data: got valid=%b instr=%h pc=%h addr=%h want 0 0000 00 00",
                  instr_valid, instr, instr_pc, imem_addr); else passed++;
      total++; if (busy !== 1'b0 || halted !== 1'b0 || pc_wrap !== 1'b0)
         $display("FAIL areset_flags: got busy=%b halted=%b wrap=%b want 0 0 0", busy, halted, pc_wrap); else passed++;
      @(posedge clk); #1;
      redirect = 1'b0;
      reset_n = 1'b1;
      tick(); tick(); tick();
      total++; if (imem_addr !== 8'h00 || busy !== 1'b0 || instr_valid !== 1'b0)
         $display("FAIL areset_idle: got addr=%h busy=%b valid=%b want 00 0 0", imem_addr, busy, instr_valid); else passed++;
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== 16'h4C05)
         $display("FAIL areset_restart: got valid=%b pc=%h instr=%h want 1 00 4c05", instr_valid, instr_pc, instr); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem[0] = 16'h4C05;
      mem[1] = 16'h2000;
      mem[2] = 16'hFC00;
      mem[3] = 16'hFE01;
      mem[4] = 16'hFFFF;
      reset_n = 1'b1;
      start = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
      #2;
      test_reset();
      test_start();
      test_backpressure();
      test_redirect_pop();
      test_halt();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
